// File: rtl/serial_add_driver_if.sv
// Parallel operand/result handshake between a word-side client and serial_add_driver.
// The master issues operand pairs and consumes results; the slave is the driver.
interface serial_add_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, cout
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result, cout
  );
endinterface

// File: rtl/serial_add_driver.sv
// Word-side end of the bit-serial adder link: streams operands LSB-first into the
// serial adder and reassembles the returned sum stream into a parallel result.
module serial_add_driver #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_add_driver_if.slave  bus,
  output logic                ser_a,
  output logic                ser_b,
  output logic                ser_clr,
  input  logic                ser_sum,
  input  logic                ser_carry
);
  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic               ser_a_q, ser_a_d;
  logic               ser_b_q, ser_b_d;
  logic               ser_clr_q, ser_clr_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    ser_a_d     = ser_a_q;
    ser_b_d     = ser_b_q;
    ser_clr_d   = ser_clr_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    cout_d      = cout_q;
    unique case (state_q)
      IDLE: begin
        ser_clr_d = 1'b1;
        ser_a_d   = 1'b0;
        ser_b_d   = 1'b0;
        if (bus.in_valid) begin
          sh_a_d    = bus.op_a;
          sh_b_d    = bus.op_b;
          ser_a_d   = bus.op_a[0];
          ser_b_d   = bus.op_b[0];
          ser_clr_d = 1'b0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        // Zeros shift in from the top, so edges past the MSB drive 0 automatically.
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        ser_a_d = sh_a_q[1];
        ser_b_d = sh_b_q[1];
        // Adder output lags the driven bit by two edges: first valid sum at cnt=1.
        if (cnt_q != '0) begin
          result_d = {ser_sum, result_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH)) begin
          cout_d      = ser_carry;
          out_valid_d = 1'b1;
          ser_clr_d   = 1'b1;
          ser_a_d     = 1'b0;
          ser_b_d     = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    sh_a_q <= sh_a_d;
    sh_b_q <= sh_b_d;
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ser_a_q     <= 1'b0;
      ser_b_q     <= 1'b0;
      ser_clr_q   <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ser_a_q     <= ser_a_d;
      ser_b_q     <= ser_b_d;
      ser_clr_q   <= ser_clr_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign ser_a         = ser_a_q;
  assign ser_b         = ser_b_q;
  assign ser_clr       = ser_clr_q;
endmodule

// File: tb/tb_serial_add_driver.sv
// Bench for serial_add_driver wired to a behavioural bit-serial adder; results are
// checked against a scoreboard of op_a+op_b pushed at each accepted operand pair.
module tb_serial_add_driver;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic ser_a, ser_b, ser_clr;
  logic ser_sum, ser_carry;

  serial_add_driver_if #(.WIDTH(W)) bus ();

  serial_add_driver #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_clr   (ser_clr),
    .ser_sum   (ser_sum),
    .ser_carry (ser_carry)
  );

  always #10 clk = ~clk;

  // Serial adder: registered sum/carry, cleared while ser_clr is high.
  always_ff @(posedge clk) begin
    if (ser_clr) begin
      ser_sum   <= 1'b0;
      ser_carry <= 1'b0;
    end else begin
      {ser_carry, ser_sum} <= 2'(ser_a) + 2'(ser_b) + 2'(ser_carry);
    end
  end

  int tests  = 0;
  int failed = 0;
  int n_acc  = 0;
  int n_res  = 0;
  logic [W:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshakes are judged at the falling edge; they complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back((W+1)'(bus.op_a) + (W+1)'(bus.op_b));
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(1), 32'(0));
        end else begin
          check("sb_result", 32'({bus.cout, bus.result}), 32'(sb.pop_front()));
          n_res++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0, res0;
    bit acc;
    int sent;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_clr",   32'(ser_clr),       32'(1));
    check("rst_ser_a",     32'(ser_a),         32'(0));
    check("rst_ser_b",     32'(ser_b),         32'(0));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_result",    32'(bus.result),    32'(0));
    check("rst_cout",      32'(bus.cout),      32'(0));
    check("rst_in_ready",  32'(bus.in_ready),  32'(1));
    rst = 1'b0;

    // 0x5A + 0x33: latency and single-cycle out_valid
    send(8'h5A, 8'h33);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.out_valid && n < 40);
    check("t1_latency", 32'(n),          32'(9));
    check("t1_result",  32'(bus.result), 32'(8'h8D));
    check("t1_cout",    32'(bus.cout),   32'(0));
    @(posedge clk); #1;
    check("t1_valid_1cyc", 32'(bus.out_valid), 32'(0));

    // Carry out, then carry isolation between operations
    send(8'hFF, 8'h01);
    wait_done();
    check("t2_result", 32'({bus.cout, bus.result}), 32'(9'h100));
    send(8'h00, 8'h00);
    wait_done();
    check("t2_zero", 32'({bus.cout, bus.result}), 32'(9'h000));

    send(8'hFF, 8'hFF);
    wait_done();
    check("t3_ffff", 32'({bus.cout, bus.result}), 32'(9'h1FE));
    send(8'h80, 8'h80);
    wait_done();
    check("t3_8080", 32'({bus.cout, bus.result}), 32'(9'h100));

    // Back-pressure in DONE with new operands pending
    bus.out_ready = 1'b0;
    send(8'h12, 8'h34);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b1;
    bus.op_a     = 8'h77;
    bus.op_b     = 8'h88;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_result",    32'(bus.result),    32'(8'h46));
      check("t4_cout",      32'(bus.cout),      32'(0));
      check("t4_in_ready",  32'(bus.in_ready),  32'(0));
      check("t4_out_valid", 32'(bus.out_valid), 32'(1));
    end
    check("t4_no_accept", 32'(n_acc), 32'(n_res + 1));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_released",   32'(bus.out_valid), 32'(0));
    check("t4_held_after", 32'(bus.result),    32'(8'h46));
    send(8'h77, 8'h88);
    wait_done();
    check("t4_second", 32'({bus.cout, bus.result}), 32'(9'h0FF));

    // Reset mid-operation
    send(8'hAA, 8'h55);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("t5_out_valid", 32'(bus.out_valid), 32'(0));
    check("t5_ser_clr",   32'(ser_clr),       32'(1));
    check("t5_in_ready",  32'(bus.in_ready),  32'(1));
    check("t5_result",    32'(bus.result),    32'(0));
    send(8'h10, 8'h20);
    wait_done();
    check("t5_after", 32'({bus.cout, bus.result}), 32'(9'h030));

    // Random traffic with random valid/ready
    acc0 = n_acc;
    res0 = n_res;
    acc  = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 5000 && sent < 50; cyc++) begin
      @(posedge clk); #1;
      if (acc) begin
        bus.in_valid = 1'b0;
        sent++;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!bus.in_valid && sent < 50 && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b1;
        bus.op_a     = W'($urandom);
        bus.op_b     = W'($urandom);
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_done();
    check("t6_accepted", 32'(n_acc - acc0), 32'(50));
    check("t6_results",  32'(n_res - res0), 32'(50));
    check("t6_sb_empty", 32'(sb.size()),    32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
